// File: rtl/e203_exu_eai_cop_arbt_pkg.sv
// Shared constants and opcode decode for the EAI coprocessor arbiter.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package e203_exu_eai_cop_arbt_pkg;

  localparam int E203_EAI_NCOP = 4;
  localparam int E203_EAI_OUTS = 4;
  localparam int E203_EAI_ID_W = 3;

  localparam logic [6:0] E203_EAI_OPC_CUSTOM0 = 7'h0B;
  localparam logic [6:0] E203_EAI_OPC_CUSTOM1 = 7'h2B;
  localparam logic [6:0] E203_EAI_OPC_CUSTOM2 = 7'h5B;
  localparam logic [6:0] E203_EAI_OPC_CUSTOM3 = 7'h7B;

  typedef logic [E203_EAI_ID_W-1:0] eai_id_t;

  localparam eai_id_t E203_EAI_ID_UNMAP = 3'b100;

  // The custom opcodes differ only in bits [6:5], which double as the
  // coprocessor index. Anything else, or an index past the populated
  // coprocessors, gets the unmapped ID so the arbiter answers it itself.
  function automatic eai_id_t eai_decode(input logic [6:0] opc, input int ncop);
    eai_id_t id;
    id = E203_EAI_ID_UNMAP;
    if (((opc == E203_EAI_OPC_CUSTOM0) || (opc == E203_EAI_OPC_CUSTOM1) ||
         (opc == E203_EAI_OPC_CUSTOM2) || (opc == E203_EAI_OPC_CUSTOM3)) &&
        (int'(opc[6:5]) < ncop)) begin
      id = {1'b0, opc[6:5]};
    end
    return id;
  endfunction

endpackage

// File: rtl/sirv_gnrl_fifo.sv
// Generic synchronous FIFO, DP entries of DW bits, pointer/count based.
// Latency: a push is visible at o_dat/o_vld the cycle after the write edge.
// Backpressure: CUT_READY=1 gives i_rdy = ~full (no pop-through); else i_rdy also rises on a same-cycle pop.
// Ports: clk, rst_n (async active-low); i_vld/i_rdy/i_dat write side; o_vld/o_rdy/o_dat read side.
module sirv_gnrl_fifo #(
  parameter int CUT_READY = 0,
  parameter int DP        = 8,
  parameter int DW        = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_vld,
  output logic          i_rdy,
  input  logic [DW-1:0] i_dat,
  output logic          o_vld,
  input  logic          o_rdy,
  output logic [DW-1:0] o_dat
);

  localparam int AW = $clog2(DP);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DP);

  logic [DW-1:0] mem_q [DP];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full, empty, push, pop;

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);
  assign i_rdy = (CUT_READY != 0) ? ~full : (~full | o_rdy);
  assign o_vld = ~empty;
  assign o_dat = mem_q[rptr_q];
  assign push  = i_vld & i_rdy;
  assign pop   = o_vld & o_rdy;

  // DP is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    wptr_d = wptr_q + AW'(push);
    rptr_d = rptr_q + AW'(pop);
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: an entry is only read once the count covers it.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= i_dat;
  end

endmodule

// File: rtl/e203_exu_eai_cop_arbt.sv
// Routes EAI requests to NCOP coprocessors by custom opcode; returns responses in issue order.
// Latency: zero-cycle request/response pass-through; an unmapped request answers one cycle after acceptance.
// Backpressure: request stalls on target not ready or OUTS outstanding; out-of-order coprocessor responses are held off.
// Ports: eai_req_* / eai_rsp_* face the EXU; cop_req_* / cop_rsp_* face the coprocessors
// (instr/rs1/rs2 broadcast, per-coprocessor valid/ready, response k at cop_rsp_dat[k*XLEN +: XLEN]); eai_busy = anything outstanding.
module e203_exu_eai_cop_arbt
  import e203_exu_eai_cop_arbt_pkg::*;
#(
  parameter int NCOP = E203_EAI_NCOP,
  parameter int OUTS = E203_EAI_OUTS,
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 eai_req_valid,
  output logic                 eai_req_ready,
  input  logic [XLEN-1:0]      eai_req_instr,
  input  logic [XLEN-1:0]      eai_req_rs1,
  input  logic [XLEN-1:0]      eai_req_rs2,
  output logic                 eai_rsp_valid,
  input  logic                 eai_rsp_ready,
  output logic [XLEN-1:0]      eai_rsp_dat,
  output logic                 eai_rsp_err,
  output logic                 eai_busy,
  output logic [NCOP-1:0]      cop_req_valid,
  input  logic [NCOP-1:0]      cop_req_ready,
  output logic [XLEN-1:0]      cop_req_instr,
  output logic [XLEN-1:0]      cop_req_rs1,
  output logic [XLEN-1:0]      cop_req_rs2,
  input  logic [NCOP-1:0]      cop_rsp_valid,
  output logic [NCOP-1:0]      cop_rsp_ready,
  input  logic [NCOP*XLEN-1:0] cop_rsp_dat,
  input  logic [NCOP-1:0]      cop_rsp_err
);

  eai_id_t req_id, head_id;
  logic    req_mapped, sel_req_rdy;
  logic    fifo_i_vld, fifo_i_rdy, fifo_o_vld, fifo_o_rdy;

  assign cop_req_instr = eai_req_instr;
  assign cop_req_rs1   = eai_req_rs1;
  assign cop_req_rs2   = eai_req_rs2;

  assign req_id     = eai_decode(eai_req_instr[6:0], NCOP);
  assign req_mapped = ~req_id[2];

  // Request steering. Unmapped requests have no downstream ready to wait
  // for, so sel_req_rdy stays 1 and only FIFO space gates them.
  always_comb begin
    cop_req_valid = '0;
    sel_req_rdy   = 1'b1;
    for (int k = 0; k < NCOP; k++) begin
      if (req_mapped && (req_id[1:0] == k[1:0])) begin
        cop_req_valid[k] = eai_req_valid & fifo_i_rdy;
        sel_req_rdy      = cop_req_ready[k];
      end
    end
  end

  assign eai_req_ready = sel_req_rdy & fifo_i_rdy;
  assign fifo_i_vld    = eai_req_valid & sel_req_rdy;

  // Response merge keyed on the oldest outstanding target. Only the head's
  // coprocessor ever sees ready, so a response that arrives early simply
  // waits in its coprocessor.
  always_comb begin
    eai_rsp_valid = 1'b0;
    eai_rsp_dat   = '0;
    eai_rsp_err   = 1'b0;
    cop_rsp_ready = '0;
    if (fifo_o_vld) begin
      if (head_id[2]) begin
        eai_rsp_valid = 1'b1;
        eai_rsp_err   = 1'b1;
      end else begin
        for (int k = 0; k < NCOP; k++) begin
          if (head_id[1:0] == k[1:0]) begin
            eai_rsp_valid    = cop_rsp_valid[k];
            eai_rsp_dat      = cop_rsp_dat[k*XLEN +: XLEN];
            eai_rsp_err      = cop_rsp_err[k];
            cop_rsp_ready[k] = eai_rsp_ready;
          end
        end
      end
    end
  end

  assign fifo_o_rdy = eai_rsp_valid & eai_rsp_ready;
  assign eai_busy   = fifo_o_vld;

  // CUT_READY keeps request-ready independent of response-ready: when full,
  // a same-cycle pop does not admit a new request.
  sirv_gnrl_fifo #(
    .CUT_READY (1),
    .DP        (OUTS),
    .DW        (E203_EAI_ID_W)
  ) u_ord_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .i_vld (fifo_i_vld),
    .i_rdy (fifo_i_rdy),
    .i_dat (req_id),
    .o_vld (fifo_o_vld),
    .o_rdy (fifo_o_rdy),
    .o_dat (head_id)
  );

endmodule

// File: tb/tb_e203_exu_eai_cop_arbt.sv
// Self-checking bench: coprocessor models plus an issue-order scoreboard.
// Latency: n/a (testbench).
// Backpressure: randomized request/response stalls.
module tb_e203_exu_eai_cop_arbt;

  localparam int XLEN = 32;
  localparam int NCOP = 4;
  localparam int OUTS = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 eai_req_valid = 1'b0, eai_req_ready;
  logic [XLEN-1:0]      eai_req_instr = 32'h33, eai_req_rs1 = '0, eai_req_rs2 = '0;
  logic                 eai_rsp_valid, eai_rsp_ready = 1'b0;
  logic [XLEN-1:0]      eai_rsp_dat;
  logic                 eai_rsp_err, eai_busy;
  logic [NCOP-1:0]      cop_req_valid, cop_req_ready = '0;
  logic [XLEN-1:0]      cop_req_instr, cop_req_rs1, cop_req_rs2;
  logic [NCOP-1:0]      cop_rsp_valid = '0, cop_rsp_ready;
  logic [NCOP*XLEN-1:0] cop_rsp_dat = '0;
  logic [NCOP-1:0]      cop_rsp_err = '0;

  e203_exu_eai_cop_arbt #(.NCOP(NCOP), .OUTS(OUTS), .XLEN(XLEN)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .eai_req_valid(eai_req_valid), .eai_req_ready(eai_req_ready),
    .eai_req_instr(eai_req_instr), .eai_req_rs1(eai_req_rs1), .eai_req_rs2(eai_req_rs2),
    .eai_rsp_valid(eai_rsp_valid), .eai_rsp_ready(eai_rsp_ready),
    .eai_rsp_dat(eai_rsp_dat), .eai_rsp_err(eai_rsp_err), .eai_busy(eai_busy),
    .cop_req_valid(cop_req_valid), .cop_req_ready(cop_req_ready),
    .cop_req_instr(cop_req_instr), .cop_req_rs1(cop_req_rs1), .cop_req_rs2(cop_req_rs2),
    .cop_rsp_valid(cop_rsp_valid), .cop_rsp_ready(cop_rsp_ready),
    .cop_rsp_dat(cop_rsp_dat), .cop_rsp_err(cop_rsp_err)
  );

  // Second instance with only two coprocessors populated.
  logic            n2_req_valid = 1'b0, n2_req_ready;
  logic [XLEN-1:0] n2_instr = 32'h33;
  logic            n2_rsp_valid, n2_rsp_ready = 1'b0;
  logic [XLEN-1:0] n2_rsp_dat;
  logic            n2_rsp_err, n2_busy;
  logic [1:0]      n2_cop_req_valid, n2_cop_req_ready = 2'b11;
  logic [XLEN-1:0] n2_cop_req_instr, n2_cop_req_rs1, n2_cop_req_rs2;
  logic [1:0]      n2_cop_rsp_valid = '0, n2_cop_rsp_ready;
  logic [2*XLEN-1:0] n2_cop_rsp_dat = '0;
  logic [1:0]      n2_cop_rsp_err = '0;

  e203_exu_eai_cop_arbt #(.NCOP(2), .OUTS(OUTS), .XLEN(XLEN)) u_dut_n2 (
    .clk(clk), .rst_n(rst_n),
    .eai_req_valid(n2_req_valid), .eai_req_ready(n2_req_ready),
    .eai_req_instr(n2_instr), .eai_req_rs1(eai_req_rs1), .eai_req_rs2(eai_req_rs2),
    .eai_rsp_valid(n2_rsp_valid), .eai_rsp_ready(n2_rsp_ready),
    .eai_rsp_dat(n2_rsp_dat), .eai_rsp_err(n2_rsp_err), .eai_busy(n2_busy),
    .cop_req_valid(n2_cop_req_valid), .cop_req_ready(n2_cop_req_ready),
    .cop_req_instr(n2_cop_req_instr), .cop_req_rs1(n2_cop_req_rs1), .cop_req_rs2(n2_cop_req_rs2),
    .cop_rsp_valid(n2_cop_rsp_valid), .cop_rsp_ready(n2_cop_rsp_ready),
    .cop_rsp_dat(n2_cop_rsp_dat), .cop_rsp_err(n2_cop_rsp_err)
  );

  typedef struct packed {
    logic [2:0]  tgt;
    logic        err;
    logic [31:0] dat;
  } exp_t;

  exp_t            sb[$];            // expected responses, issue order
  logic [32:0]     copq[NCOP][$];    // per-coprocessor pending results {err, dat}
  logic [NCOP-1:0] rsp_en = '0;      // coprocessor willing to raise a response
  logic [NCOP-1:0] hold = '0;        // response raised and not yet taken
  logic            req_acc = 1'b0;
  int              n_cmp = 0, n_bad = 0, n_issued = 0, n_done = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Coprocessor index from the table of custom opcodes, or 4 = unmapped.
  function automatic logic [2:0] ref_tgt(input logic [31:0] ins, input int ncop);
    int idx;
    case (ins[6:0])
      7'h0B:   idx = 0;
      7'h2B:   idx = 1;
      7'h5B:   idx = 2;
      7'h7B:   idx = 3;
      default: idx = -1;
    endcase
    if (idx >= 0 && idx < ncop) return 3'(idx);
    return 3'b100;
  endfunction

  // What coprocessor k computes: {err, dat}.
  function automatic logic [32:0] cop_result(input int k, input logic [31:0] a, input logic [31:0] b);
    return {a[31] ^ b[0], a ^ (b << k)};
  endfunction

  task automatic drive_cop();
    for (int k = 0; k < NCOP; k++) begin
      if (copq[k].size() > 0 && (hold[k] || rsp_en[k])) begin
        cop_rsp_valid[k] = 1'b1;
        {cop_rsp_err[k], cop_rsp_dat[k*XLEN +: XLEN]} = copq[k][0];
      end else begin
        cop_rsp_valid[k] = 1'b0;
        cop_rsp_err[k] = 1'b0;
        cop_rsp_dat[k*XLEN +: XLEN] = '0;
      end
    end
  endtask

  task automatic check_cycle();
    logic [2:0]      t;
    int              occ;
    logic            exp_rdy, exp_rv;
    logic [NCOP-1:0] exp_crv, exp_crr, acc;
    logic [32:0]     r;
    exp_t            h, e;
    occ = sb.size();
    t = ref_tgt(eai_req_instr, NCOP);
    exp_rdy = (occ < OUTS) && (t[2] || cop_req_ready[t[1:0]]);
    exp_crv = '0;
    if (!t[2] && occ < OUTS && eai_req_valid) exp_crv[t[1:0]] = 1'b1;
    chk("req_ready", 32'(eai_req_ready), 32'(exp_rdy));
    chk("cop_req_valid", 32'(cop_req_valid), 32'(exp_crv));
    chk("busy", 32'(eai_busy), 32'(occ != 0));
    if (eai_req_valid) begin
      chk("pass_instr", cop_req_instr, eai_req_instr);
      chk("pass_rs2", cop_req_rs2, eai_req_rs2);
    end
    exp_rv = 1'b0;
    exp_crr = '0;
    acc = '0;
    h = '0;
    if (occ > 0) begin
      h = sb[0];
      if (h.tgt[2]) exp_rv = 1'b1;
      else begin
        exp_rv = cop_rsp_valid[h.tgt[1:0]];
        exp_crr[h.tgt[1:0]] = eai_rsp_ready;
      end
    end
    chk("rsp_valid", 32'(eai_rsp_valid), 32'(exp_rv));
    chk("cop_rsp_ready", 32'(cop_rsp_ready), 32'(exp_crr));
    if (exp_rv) begin
      chk("rsp_dat", eai_rsp_dat, h.dat);
      chk("rsp_err", 32'(eai_rsp_err), 32'(h.err));
    end else if (occ == 0) begin
      chk("rsp_dat_idle", eai_rsp_dat, 32'h0);
    end
    req_acc = 1'b0;
    if (rst_n) begin
      if (exp_rv && eai_rsp_ready) begin
        void'(sb.pop_front());
        n_done++;
        if (!h.tgt[2]) begin
          void'(copq[h.tgt[1:0]].pop_front());
          acc[h.tgt[1:0]] = 1'b1;
        end
      end
      req_acc = eai_req_valid && exp_rdy;
      if (req_acc) begin
        r = t[2] ? {1'b1, 32'h0} : cop_result(int'(t[1:0]), eai_req_rs1, eai_req_rs2);
        e.tgt = t;
        e.err = r[32];
        e.dat = r[31:0];
        sb.push_back(e);
        if (!t[2]) copq[t[1:0]].push_back(r);
        n_issued++;
      end
    end
    hold = cop_rsp_valid & ~acc;
  endtask

  task automatic step();
    drive_cop();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    rsp_en = '1;
    eai_rsp_ready = 1'b1;
    eai_req_valid = 1'b0;
    for (int i = 0; i < 60 && sb.size() > 0; i++) step();
    chk(tag, 32'(sb.size()), 32'h0);
  endtask

  task automatic issue(input logic [6:0] opc, input logic [31:0] a, input logic [31:0] b);
    eai_req_valid = 1'b1;
    eai_req_instr = {25'h0, opc};
    eai_req_rs1 = a;
    eai_req_rs2 = b;
    step();
    eai_req_valid = 1'b0;
  endtask

  logic [32:0] r2;

  initial begin
    // Reset state
    #12;
    chk("rst_busy", 32'(eai_busy), 32'h0);
    chk("rst_rsp_valid", 32'(eai_rsp_valid), 32'h0);
    chk("rst_cop_req_valid", 32'(cop_req_valid), 32'h0);
    chk("rst_cop_rsp_ready", 32'(cop_rsp_ready), 32'h0);
    chk("rst_ready_unmapped", 32'(eai_req_ready), 32'h1);
    eai_req_instr = 32'h2B;
    #1 chk("rst_ready_mapped_lo", 32'(eai_req_ready), 32'h0);
    cop_req_ready = 4'b0010;
    #1 chk("rst_ready_mapped_hi", 32'(eai_req_ready), 32'h1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single custom-1 request and response
    eai_req_valid = 1'b1;
    eai_req_instr = 32'h0000_002B;
    eai_req_rs1 = 32'h1234;
    eai_req_rs2 = 32'h0;
    #1 chk("t1_cop_req_valid", 32'(cop_req_valid), 32'h2);
    step();
    eai_req_valid = 1'b0;
    chk("t1_busy", 32'(eai_busy), 32'h1);
    rsp_en = 4'b0010;
    eai_rsp_ready = 1'b1;
    drive_cop();
    #1;
    chk("t1_rsp_valid", 32'(eai_rsp_valid), 32'h1);
    chk("t1_rsp_dat", eai_rsp_dat, 32'h1234);
    step();
    chk("t1_busy_after", 32'(eai_busy), 32'h0);

    // Out-of-order response from cop0 is held off behind cop2
    cop_req_ready = '1;
    rsp_en = '0;
    issue(7'h5B, 32'hAAAA, 32'h3);
    issue(7'h0B, 32'h5555, 32'h7);
    rsp_en = 4'b0001;
    drive_cop();
    #1;
    chk("t2_cop0_ready", 32'(cop_rsp_ready[0]), 32'h0);
    chk("t2_rsp_valid", 32'(eai_rsp_valid), 32'h0);
    step();
    step();
    rsp_en = 4'b0101;
    drive_cop();
    #1;
    r2 = cop_result(2, 32'hAAAA, 32'h3);
    chk("t2_first_dat", eai_rsp_dat, r2[31:0]);
    drain("t2_drain");

    // Only two coprocessors: custom-3 and opcode 0x33 are both unmapped
    n2_req_valid = 1'b1;
    n2_instr = 32'h7B;
    #1;
    chk("n2_cop_req_valid", 32'(n2_cop_req_valid), 32'h0);
    chk("n2_req_ready", 32'(n2_req_ready), 32'h1);
    @(posedge clk);
    #1 n2_instr = 32'h33;
    #1;
    chk("n2_cop_req_valid2", 32'(n2_cop_req_valid), 32'h0);
    chk("n2_rsp_valid_next", 32'(n2_rsp_valid), 32'h1);
    @(posedge clk);
    #1 n2_req_valid = 1'b0;
    n2_rsp_ready = 1'b1;
    #1;
    chk("n2_rsp1_err", 32'(n2_rsp_err), 32'h1);
    chk("n2_rsp1_dat", n2_rsp_dat, 32'h0);
    @(posedge clk);
    #1;
    chk("n2_rsp2_valid", 32'(n2_rsp_valid), 32'h1);
    chk("n2_rsp2_err", 32'(n2_rsp_err), 32'h1);
    chk("n2_rsp2_dat", n2_rsp_dat, 32'h0);
    @(posedge clk);
    #1 chk("n2_busy_end", 32'(n2_busy), 32'h0);
    n2_rsp_ready = 1'b0;

    // Full: no admission even with a same-cycle pop
    rsp_en = '0;
    eai_rsp_ready = 1'b0;
    for (int i = 0; i < OUTS; i++) issue(7'h7B, 32'(i + 16), 32'h1);
    eai_req_valid = 1'b1;
    eai_req_instr = 32'h0B;
    #1 chk("t4_full_ready", 32'(eai_req_ready), 32'h0);
    rsp_en = 4'b1000;
    eai_rsp_ready = 1'b1;
    drive_cop();
    #1;
    chk("t4_pop_ready", 32'(eai_req_ready), 32'h0);
    chk("t4_pop_valid", 32'(eai_rsp_valid), 32'h1);
    step();
    eai_rsp_ready = 1'b0;
    rsp_en = '0;
    chk("t4_next_ready", 32'(eai_req_ready), 32'h1);
    step();
    eai_req_valid = 1'b0;
    drain("t4_drain");

    // Reset with three requests outstanding
    rsp_en = '0;
    eai_rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) issue(7'h2B, 32'(i + 100), 32'h2);
    chk("t5_busy_before", 32'(eai_busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("t5_busy_rst", 32'(eai_busy), 32'h0);
    chk("t5_rsp_valid_rst", 32'(eai_rsp_valid), 32'h0);
    sb.delete();
    for (int k = 0; k < NCOP; k++) copq[k].delete();
    hold = '0;
    step();
    step();
    rst_n = 1'b1;
    issue(7'h5B, 32'h77, 32'h9);
    drain("t5_drain");
    chk("t5_busy_end", 32'(eai_busy), 32'h0);

    // Randomized traffic
    n_issued = 0;
    n_done = 0;
    req_acc = 1'b0;
    eai_req_valid = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (!(eai_req_valid && !req_acc)) begin
        eai_req_valid = ($urandom_range(0, 9) < 6);
        eai_req_instr = $urandom();
        case ($urandom_range(0, 5))
          0: eai_req_instr[6:0] = 7'h0B;
          1: eai_req_instr[6:0] = 7'h2B;
          2: eai_req_instr[6:0] = 7'h5B;
          3: eai_req_instr[6:0] = 7'h7B;
          4: eai_req_instr[6:0] = 7'h33;
          default: eai_req_instr[6:0] = 7'h7F;
        endcase
        eai_req_rs1 = $urandom();
        eai_req_rs2 = $urandom();
      end
      cop_req_ready = 4'($urandom());
      eai_rsp_ready = ($urandom_range(0, 3) != 0);
      rsp_en = 4'($urandom());
      step();
    end
    drain("rand_drain");
    chk("rand_issue_vs_done", 32'(n_done), 32'(n_issued));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/e203_exu_eai_cop_arbt.md
# e203_exu_eai_cop_arbt

Routes the single EAI request channel from the execution unit to up to four coprocessors, chosen by the custom opcode of each instruction. Merges their multi-cycle responses back onto the single EAI response channel in strict issue order. Sits between the EAI request/response ports of the EXU and the coprocessor ports at the core boundary. It tracks outstanding operations in an ordering FIFO of target IDs, and answers unmapped instructions itself with an error response.

## Interface

Parameters:
- NCOP, 4: number of attached coprocessors, range 1..4.
- OUTS, 4: maximum outstanding requests (ordering FIFO depth), power of two, at least 2.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; asynchronous, active-low
- eai_req_valid  in  1  request valid from EXU
- eai_req_ready  out  1  request accepted
- eai_req_instr  in  XLEN  instruction word
- eai_req_rs1  in  XLEN  operand 1
- eai_req_rs2  in  XLEN  operand 2
- eai_rsp_valid  out  1  response valid to EXU
- eai_rsp_ready  in  1  EXU takes response
- eai_rsp_dat  out  XLEN  result data
- eai_rsp_err  out  1  response error
- eai_busy  out  1  at least one request outstanding
- cop_req_valid  out  NCOP  per-coprocessor request valid
- cop_req_ready  in  NCOP  per-coprocessor request ready
- cop_req_instr  out  XLEN  broadcast instruction
- cop_req_rs1  out  XLEN  broadcast operand 1
- cop_req_rs2  out  XLEN  broadcast operand 2
- cop_rsp_valid  in  NCOP  per-coprocessor response valid
- cop_rsp_ready  out  NCOP  per-coprocessor response ready
- cop_rsp_dat  in  NCOP*XLEN  packed responses; coprocessor k occupies bits [k*XLEN +: XLEN]
- cop_rsp_err  in  NCOP  per-coprocessor error

## Operation

- Decode:
  - Mapped when instr[6:0] is one of 0x0B, 0x2B, 0x5B, 0x7B and instr[6:5] < NCOP.
  - Target ID = {1'b0, instr[6:5]}.
  - Otherwise unmapped, target ID = 3'b100.
- Request, mapped case:
  - cop_req_valid[id] = eai_req_valid & ~fifo_full.
  - eai_req_ready = cop_req_ready[id] & ~fifo_full.
  - All other cop_req_valid bits are 0.
- Request, unmapped case: eai_req_ready = ~fifo_full; no cop_req_valid is asserted.
- Every request handshake pushes the target ID into the ordering FIFO.
- cop_req_instr, cop_req_rs1 and cop_req_rs2 are pass-through of the eai_req_* values.
- Response path, keyed on FIFO head ID h when the FIFO is non-empty:
  - Head mapped: eai_rsp_valid = cop_rsp_valid[h]; eai_rsp_dat and eai_rsp_err come from coprocessor h; cop_rsp_ready[h] = eai_rsp_ready.
  - Head unmapped: eai_rsp_valid = 1, eai_rsp_dat = 0, eai_rsp_err = 1.
  - Every cop_rsp_ready bit other than the head's is 0. Out-of-order coprocessor responses are back-pressured, never dropped.
- Pop on eai_rsp_valid & eai_rsp_ready.
- Empty FIFO: eai_rsp_valid = 0, all cop_rsp_ready = 0, eai_rsp_dat = 0.
- eai_busy = FIFO non-empty.

## Timing

- Request and response paths are combinational: zero-cycle pass-through. The only state is the FIFO storage, the read/write pointers and the count.
- Push takes effect at the clock edge of the handshake. The entry is visible at the head in the next cycle.
  - Consequence: an unmapped request issued into an empty FIFO responds one cycle after acceptance.
- Full: eai_req_ready = 0 even if a pop happens in the same cycle. No bypass; this breaks the ready→valid loop.
- Simultaneous push and pop when neither full nor empty: count unchanged, both pointers advance.
- Pointers wrap modulo OUTS. The count has log2(OUTS)+1 bits and saturates at OUTS by construction.
- Handshake rules:
  - Upstream must hold request fields stable while valid & ~ready.
  - This block holds eai_rsp_* stable while eai_rsp_valid & ~eai_rsp_ready, provided the selected coprocessor does the same.
- Reset (asynchronous, any time, including mid-transaction):
  - Pointers and count clear to 0, so eai_busy = 0 and eai_rsp_valid = 0.
  - Outstanding IDs are discarded. Coprocessors are reset by the same rst_n.
- Reset values of outputs:
  - eai_req_ready = 1 (FIFO empty) for an unmapped request; for a mapped request it follows cop_req_ready.
  - All other control outputs are 0.

## Structure

- Add to e203_defines.v:
  - E203_EAI_NCOP
  - E203_EAI_OUTS
  - the four custom opcode constants
  - E203_EAI_ID_W = 3
  - E203_EAI_ID_UNMAP = 3'b100
- Ordering FIFO: instantiate sirv_gnrl_fifo with DP=OUTS, DW=E203_EAI_ID_W, CUT_READY=1, using its i_rdy as ~fifo_full. No other sub-module.

## Test plan

- Custom-1 request (instr = 0x0000_002B), cop1 ready → cop_req_valid = 4'b0010 and FIFO count = 1. Cop1 then responds with dat 0x1234, err 0 → eai_rsp_dat = 0x1234, eai_busy falls to 0.
- Issue cop2 then cop0. Cop0 responds first → cop_rsp_ready[0] = 0 and eai_rsp_valid = 0 until cop2 responds. Then output order is cop2 then cop0.
- With NCOP = 2, a custom-3 request and an opcode 0x33 request → no cop_req_valid. Two responses follow, each with err = 1 and dat = 0, in issue order.
- Issue OUTS requests with no responses → eai_req_ready = 0. Pop one in the same cycle a fifth request is presented → that fifth request is not accepted until the next cycle.
- Continuous back-to-back issue and response with random ready stalls over 1000 cycles → every response matches the issue-order scoreboard, with no loss or duplication.
- Assert rst_n low with 3 requests outstanding → eai_busy = 0 and eai_rsp_valid = 0 immediately. After release, a new request completes normally.
